// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, fixed-width memory strobe.
// Address and data settle for a cycle before and after every strobe.
module load_store_unit #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RELEASE,
        RESPOND
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic        req_bad;

    assign req_bad = (req_addr[1:0] != 2'b00) || (req_addr[31:14] != 18'd0);

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_en_d = rd_en_q;
        wr_en_d = wr_en_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    if (req_bad) begin
                        state_d = RESPOND;
                        valid_d = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                        addr_d  = {2'b00, req_addr[31:2]};
                        wdata_d = req_wdata;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CNT_INIT;
                rd_en_d = ~write_q;
                wr_en_d = write_q;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RELEASE;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    if (!write_q) begin
                        rdata_d = mem_read_data;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RELEASE: begin
                state_d = RESPOND;
                valid_d = 1'b1;
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    // Ready is withheld while reset is held so nothing is accepted then.
    assign req_ready        = (state_q == IDLE) && !reset;
    assign resp_valid       = valid_q;
    assign resp_error       = error_q;
    assign resp_rdata       = rdata_q;
    assign mem_address      = addr_q;
    assign mem_read_enable  = rd_en_q;
    assign mem_write_enable = wr_en_q;
    assign mem_write_data   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: three instances (WAIT_CYCLES 1, 2, 15)
// checked against a transaction-level model with a reference memory.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_valid = 3'b000;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;

    logic        req_ready[3];
    logic        resp_valid[3];
    logic        resp_error[3];
    logic        rd_en[3];
    logic        wr_en[3];
    logic [31:0] resp_rdata[3];
    logic [31:0] mem_address[3];
    logic [31:0] mem_wdata[3];
    logic [31:0] mem_rdata[3];

    logic [31:0] env_mem[4096];
    bit          env_written[4096];
    logic [31:0] ref_mem[4096];
    logic [31:0] exp_addr[3];
    logic [31:0] exp_wdata[3];
    logic [31:0] exp_rdata[3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] init_val(input logic [11:0] w);
        return {w, 20'h0} ^ 32'h3C5A_96E1 ^ {20'h0, w};
    endfunction

    function automatic int wof(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 15);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        load_store_unit #(
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 2 : 15))
        ) u_dut (
            .clock           (clock),
            .reset           (reset),
            .req_valid       (req_valid[g]),
            .req_ready       (req_ready[g]),
            .req_write       (req_write),
            .req_addr        (req_addr),
            .req_wdata       (req_wdata),
            .resp_valid      (resp_valid[g]),
            .resp_error      (resp_error[g]),
            .resp_rdata      (resp_rdata[g]),
            .mem_address     (mem_address[g]),
            .mem_read_enable (rd_en[g]),
            .mem_write_enable(wr_en[g]),
            .mem_write_data  (mem_wdata[g]),
            .mem_read_data   (mem_rdata[g])
        );
        assign mem_rdata[g] = env_written[mem_address[g][11:0]]
                            ? env_mem[mem_address[g][11:0]]
                            : init_val(mem_address[g][11:0]);
    end

    // Memory environment: a write strobe stores data on each edge it is high.
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (wr_en[i]) begin
                env_mem[mem_address[i][11:0]]     <= mem_wdata[i];
                env_written[mem_address[i][11:0]] <= 1'b1;
            end
        end
    end

    task automatic run_txn(input int i, input bit wr,
                           input logic [31:0] addr, input logic [31:0] data);
        int w, endk, rd_n, wr_n, first_s, last_s, resp_n, resp_k, ready_k;
        int viol, addr_bad;
        bit bad;
        logic err_s, prev_rd, prev_wr;
        logic [31:0] rdata_s, prev_a;
        w = wof(i);
        bad = (addr[1:0] != 2'b00) || (addr[31:14] != 18'd0);
        n_vec++;
        if (req_ready[i] !== 1'b1) begin
            n_err++;
            $display("FAIL ready_before inst%0d: got %b want 1", i, req_ready[i]);
        end
        if (!bad) begin
            exp_addr[i]  = {2'b00, addr[31:2]};
            exp_wdata[i] = data;
            if (!wr) exp_rdata[i] = ref_mem[addr[13:2]];
        end
        req_valid = 3'b001 << i;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        prev_rd = rd_en[i];
        prev_wr = wr_en[i];
        prev_a  = mem_address[i];
        rd_n = 0; wr_n = 0; first_s = 0; last_s = 0;
        resp_n = 0; resp_k = 0; ready_k = 0; viol = 0; addr_bad = 0;
        err_s = 1'b0; rdata_s = resp_rdata[i];
        endk = bad ? 2 : 4 + w;
        @(posedge clock);
        for (int k = 1; k <= endk; k++) begin
            @(negedge clock);
            if (rd_en[i] || wr_en[i]) begin
                if (first_s == 0) first_s = k;
                last_s = k;
            end
            if (rd_en[i]) rd_n++;
            if (wr_en[i]) wr_n++;
            if (rd_en[i] && wr_en[i]) viol++;
            if (resp_error[i] && !resp_valid[i]) viol++;
            if ((mem_address[i] !== prev_a) &&
                ((rd_en[i] !== prev_rd) || (wr_en[i] !== prev_wr))) viol++;
            if (resp_valid[i]) begin
                resp_n++;
                resp_k  = k;
                err_s   = resp_error[i];
                rdata_s = resp_rdata[i];
            end
            if (req_ready[i] && ready_k == 0) ready_k = k;
            if (mem_address[i] !== exp_addr[i]) addr_bad++;
            if (mem_wdata[i] !== exp_wdata[i]) addr_bad++;
            prev_rd = rd_en[i];
            prev_wr = wr_en[i];
            prev_a  = mem_address[i];
            req_valid = 3'b000;
            req_write = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = $urandom;
        end
        n_vec++;
        if (rd_n !== ((!bad && !wr) ? w : 0)) begin
            n_err++;
            $display("FAIL rd_strobes inst%0d addr %h: got %0d want %0d",
                     i, addr, rd_n, (!bad && !wr) ? w : 0);
        end
        n_vec++;
        if (wr_n !== ((!bad && wr) ? w : 0)) begin
            n_err++;
            $display("FAIL wr_strobes inst%0d addr %h: got %0d want %0d",
                     i, addr, wr_n, (!bad && wr) ? w : 0);
        end
        n_vec++;
        if (first_s !== (bad ? 0 : 2) || last_s !== (bad ? 0 : 1 + w)) begin
            n_err++;
            $display("FAIL strobe_window inst%0d: got %0d..%0d want %0d..%0d",
                     i, first_s, last_s, bad ? 0 : 2, bad ? 0 : 1 + w);
        end
        n_vec++;
        if (resp_n !== 1 || resp_k !== (bad ? 1 : 3 + w)) begin
            n_err++;
            $display("FAIL resp_cycle inst%0d: got %0d pulses at %0d want 1 at %0d",
                     i, resp_n, resp_k, bad ? 1 : 3 + w);
        end
        n_vec++;
        if (err_s !== bad) begin
            n_err++;
            $display("FAIL resp_error inst%0d addr %h: got %b want %b", i, addr, err_s, bad);
        end
        n_vec++;
        if (rdata_s !== exp_rdata[i]) begin
            n_err++;
            $display("FAIL resp_rdata inst%0d: got %h want %h", i, rdata_s, exp_rdata[i]);
        end
        n_vec++;
        if (ready_k !== endk) begin
            n_err++;
            $display("FAIL ready_return inst%0d: got %0d want %0d", i, ready_k, endk);
        end
        n_vec++;
        if (addr_bad !== 0) begin
            n_err++;
            $display("FAIL addr_data_hold inst%0d: got %0d bad cycles want 0", i, addr_bad);
        end
        n_vec++;
        if (viol !== 0) begin
            n_err++;
            $display("FAIL strobe_rules inst%0d: got %0d violations want 0", i, viol);
        end
        if (!bad && wr) ref_mem[addr[13:2]] = data;
    endtask

    task automatic test_reset();
        #3;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({req_ready[i], resp_valid[i], resp_error[i], rd_en[i], wr_en[i],
                 resp_rdata[i], mem_address[i], mem_wdata[i]} !== 101'd0) begin
                n_err++;
                $display("FAIL reset_outputs inst%0d: got rdy%b v%b e%b rd%b wr%b %h %h %h want all 0",
                         i, req_ready[i], resp_valid[i], resp_error[i], rd_en[i], wr_en[i],
                         resp_rdata[i], mem_address[i], mem_wdata[i]);
            end
        end
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (req_ready[i] !== 1'b1) begin
                n_err++;
                $display("FAIL reset_release_ready inst%0d: got %b want 1", i, req_ready[i]);
            end
        end
    endtask

    task automatic test_directed();
        run_txn(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        run_txn(1, 1'b0, 32'h0000_0010, 32'h0);
        run_txn(1, 1'b0, 32'h0000_0012, 32'h0);
        run_txn(1, 1'b0, 32'h0001_0000, 32'h0);
        run_txn(1, 1'b1, 32'h0000_3FFF, 32'h1234_5678);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, a2, d1, d2;
        int ready_bad, addr_bad, guard;
        a1 = {18'd0, 12'($urandom_range(0, 31)), 2'b00};
        a2 = {18'd0, 12'($urandom_range(0, 31)), 2'b00};
        d1 = $urandom;
        d2 = $urandom;
        ready_bad = 0;
        addr_bad = 0;
        req_valid = 3'b010;
        req_write = 1'b1;
        req_addr  = a1;
        req_wdata = d1;
        @(posedge clock);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (req_ready[1] !== (k == 6)) ready_bad++;
            if (mem_address[1] !== {2'b00, a1[31:2]}) addr_bad++;
            if (mem_wdata[1] !== d1) addr_bad++;
            if (k < 5) begin
                req_addr  = $urandom;
                req_wdata = $urandom;
            end else begin
                req_addr  = a2;
                req_wdata = d2;
            end
        end
        n_vec++;
        if (ready_bad !== 0) begin
            n_err++;
            $display("FAIL b2b_ready inst1: got %0d bad cycles want 0", ready_bad);
        end
        n_vec++;
        if (addr_bad !== 0) begin
            n_err++;
            $display("FAIL b2b_ignore_inputs inst1: got %0d bad cycles want 0", addr_bad);
        end
        @(negedge clock);
        req_valid = 3'b000;
        n_vec++;
        if (req_ready[1] !== 1'b0 || mem_address[1] !== {2'b00, a2[31:2]} ||
            mem_wdata[1] !== d2) begin
            n_err++;
            $display("FAIL b2b_second_accept inst1: got rdy%b %h %h want rdy0 %h %h",
                     req_ready[1], mem_address[1], mem_wdata[1], {2'b00, a2[31:2]}, d2);
        end
        guard = 0;
        while (req_ready[1] !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        n_vec++;
        if (guard >= 20) begin
            n_err++;
            $display("FAIL b2b_timeout inst1: got no ready in %0d cycles want ready", guard);
        end
        ref_mem[a1[13:2]] = d1;
        ref_mem[a2[13:2]] = d2;
        exp_addr[1]  = {2'b00, a2[31:2]};
        exp_wdata[1] = d2;
    endtask

    task automatic test_reset_mid();
        int pulses;
        req_valid = 3'b010;
        req_write = 1'b1;
        req_addr  = 32'h0000_3FFC;
        req_wdata = $urandom;
        @(posedge clock);
        @(negedge clock);
        req_valid = 3'b000;
        @(negedge clock);
        n_vec++;
        if (wr_en[1] !== 1'b1) begin
            n_err++;
            $display("FAIL mid_store_strobe inst1: got %b want 1", wr_en[1]);
        end
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({req_ready[i], resp_valid[i], rd_en[i], wr_en[i], mem_address[i]} !== 36'd0) begin
                n_err++;
                $display("FAIL async_reset inst%0d: got rdy%b v%b rd%b wr%b %h want all 0",
                         i, req_ready[i], resp_valid[i], rd_en[i], wr_en[i], mem_address[i]);
            end
            exp_addr[i]  = 32'd0;
            exp_wdata[i] = 32'd0;
            exp_rdata[i] = 32'd0;
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_vec++;
        if (req_ready[1] !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_release inst1: got %b want 1", req_ready[1]);
        end
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (resp_valid[1] || wr_en[1] || rd_en[1]) pulses++;
        end
        n_vec++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL abort_no_resp inst1: got %0d activity cycles want 0", pulses);
        end
    endtask

    task automatic test_random(input int i, input int n);
        bit wr;
        int r;
        logic [31:0] addr;
        for (int t = 0; t < n; t++) begin
            r    = $urandom_range(0, 9);
            wr   = 1'($urandom_range(0, 1));
            addr = {18'd0, 12'($urandom_range(0, 31)), 2'b00};
            if (r == 0) addr[1:0] = 2'($urandom_range(1, 3));
            if (r == 1) addr = addr | (32'($urandom_range(1, 262143)) << 14);
            run_txn(i, wr, addr, $urandom);
        end
    endtask

    initial begin
        for (int w = 0; w < 4096; w++) ref_mem[w] = init_val(12'(w));
        for (int i = 0; i < 3; i++) begin
            exp_addr[i]  = 32'd0;
            exp_wdata[i] = 32'd0;
            exp_rdata[i] = 32'd0;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random(0, 30);
        test_random(1, 30);
        test_random(2, 30);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of cycles the memory enable is held (legal range 1..15).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The ports SHALL be as follows, one per line:
- clock  input  1  sole clock, all state on posedge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  core presents a request
- req_ready  output  1  unit can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- resp_valid  output  1  one-cycle completion pulse
- resp_error  output  1  qualifies resp_valid: request rejected
- resp_rdata  output  32  load data
- mem_address  output  32  word index to memory
- mem_read_enable  output  1  memory read strobe
- mem_write_enable  output  1  memory write strobe
- mem_write_data  output  32  memory write data
- mem_read_data  input  32  memory read data, combinational

Function
REQ-004 The block SHALL implement a state machine with states IDLE, SETUP, ACCESS, RELEASE and RESPOND, all outputs registered.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on a posedge with req_valid=1 and req_ready=1.
REQ-006 On acceptance, the block SHALL latch req_write, mem_address={2'b00,req_addr[31:2]} and mem_write_data=req_wdata; these SHALL hold unchanged until the next acceptance.
REQ-007 A request SHALL be in error if req_addr[1:0]!=0 or req_addr[31:14]!=0; errored requests go IDLE->RESPOND, assert no memory strobe, leave mem_address and mem_write_data unchanged, and respond with resp_error=1 one cycle after acceptance.
REQ-008 A legal request SHALL go IDLE->SETUP, with enables low for one cycle so that address and data settle before any strobe.
REQ-009 In ACCESS, the block SHALL assert exactly one of mem_read_enable (load) or mem_write_enable (store) for exactly WAIT_CYCLES consecutive cycles, counted by a 4-bit down-counter loaded with WAIT_CYCLES-1.
REQ-010 On a load, the block SHALL capture mem_read_data into resp_rdata on the last ACCESS cycle edge.
REQ-011 RELEASE SHALL last one cycle, with both enables low and address and data still held.
REQ-012 RESPOND SHALL last one cycle, with resp_valid=1; the next state is IDLE.
REQ-013 Latency for a legal request SHALL be resp_valid in cycle 3+WAIT_CYCLES after the accept edge, with req_ready returning in cycle 4+WAIT_CYCLES.
REQ-014 mem_read_enable and mem_write_enable SHALL never both be 1, and SHALL never change in the same cycle that mem_address changes.
REQ-015 resp_rdata SHALL change only on a successful load and SHALL hold otherwise, including across stores and errors.
REQ-016 resp_error SHALL be 0 whenever resp_valid is 0.
REQ-017 req_valid, req_addr and req_wdata changes outside IDLE SHALL be ignored; no queuing.

Reset
REQ-018 Asserting reset SHALL immediately force IDLE and drive req_ready=0 while reset is held, with resp_valid=0, resp_error=0, resp_rdata=0, mem_address=0, mem_write_data=0 and both enables 0.
REQ-019 Reset mid-transaction SHALL abort it with no response, and a partially strobed store is not retried.
REQ-020 The first posedge after reset deassertion SHALL see req_ready=1.

Verification
REQ-021 WAIT_CYCLES=2; store addr 0x0000_0010, data 0xDEADBEEF -> mem_address=0x4, mem_write_enable high in exactly cycles 2-3, resp_valid cycle 5 with resp_error=0.
REQ-022 Load from 0x0000_0010 with memory returning 0xDEADBEEF -> mem_read_enable high in cycles 2-3 only, resp_rdata=0xDEADBEEF at resp_valid, no write strobe.
REQ-023 Load from 0x0000_0012, and separately from 0x0001_0000 -> resp_valid and resp_error=1 in cycle 1, no strobe, mem_address unchanged.
REQ-024 Back-to-back requests with req_valid held high -> second accepted only in cycle 6, and req_ready=0 throughout.
REQ-025 Reset asserted during ACCESS of a store -> enables drop asynchronously, no resp_valid, req_ready=1 on the first edge after release.
REQ-026 WAIT_CYCLES=1 and 15 sweeps -> strobe width equals WAIT_CYCLES, and the assertion of REQ-014 holds throughout.
